// File: rtl/mem_ctrl16.sv
// 32-bit CPU port to a 16-bit synchronous single-port memory: byte/halfword/word
// accesses, word splits over two halfwords, byte writes via read-modify-write.
// Optional alignment checking is enabled by defining MEMCTRL_ALIGN_CHECK_EN.
module mem_ctrl16 #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic                  cpu_req_write,
  input  logic [1:0]            cpu_req_size,
  input  logic [ADDR_WIDTH:0]   cpu_req_addr,
  input  logic [31:0]           cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [31:0]           cpu_resp_rdata,
  output logic                  cpu_resp_err,
  input  logic [15:0]           MEM_MEMCTRL_from_mem_data,
  output logic                  MEMCTRL_MEM_to_mem_read_enable,
  output logic                  MEMCTRL_MEM_to_mem_write_enable,
  output logic                  MEMCTRL_MEM_to_mem_mem_enable,
  output logic [ADDR_WIDTH-1:0] MEMCTRL_MEM_to_mem_address,
  output logic [15:0]           MEMCTRL_MEM_to_mem_data
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RMW_RD, RMW_WR, WR0, WR1, RESP} state_t;

  state_t                state_q;
  logic                  ready_q;
  logic                  resp_valid_q;
  logic                  err_q;
  logic [31:0]           rdata_q;
  logic                  rd_en_q;
  logic                  wr_en_q;
  logic                  mem_en_q;
  logic [ADDR_WIDTH-1:0] maddr_q;
  logic [15:0]           mdata_q;
  logic [1:0]            size_q;
  logic                  lane_q;
  logic [15:0]           wdata_hi_q;
  logic [7:0]            wbyte_q;
  logic [15:0]           lo_q;
  logic                  hi_q;
  logic                  req_bad;

`ifdef MEMCTRL_ALIGN_CHECK_EN
  assign req_bad = (cpu_req_size == 2'b11) ||
                   ((cpu_req_size != 2'b00) && cpu_req_addr[0]);
`else
  assign req_bad = 1'b0;
`endif

  function automatic logic [31:0] rd_result(input logic [1:0] sz, input logic lane,
                                            input logic [15:0] md, input logic [15:0] lo);
    if (sz == 2'b00)
      return {24'h0, lane ? md[15:8] : md[7:0]};
    else if (sz[1])
      return {md, lo};
    else
      return {16'h0, md};
  endfunction

  function automatic logic [15:0] rmw_merge(input logic lane, input logic [15:0] md,
                                            input logic [7:0] b);
    return lane ? {b, md[7:0]} : {md[15:8], b};
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      maddr_q      <= '0;
      mdata_q      <= '0;
      size_q       <= '0;
      lane_q       <= 1'b0;
      wdata_hi_q   <= '0;
      wbyte_q      <= '0;
      lo_q         <= '0;
      hi_q         <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cpu_req_valid) begin
            ready_q    <= 1'b0;
            size_q     <= cpu_req_size;
            lane_q     <= cpu_req_addr[0];
            wdata_hi_q <= cpu_req_wdata[31:16];
            wbyte_q    <= cpu_req_wdata[7:0];
            hi_q       <= 1'b0;
            maddr_q    <= cpu_req_addr[ADDR_WIDTH:1];
            mdata_q    <= cpu_req_wdata[15:0];
            if (req_bad) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              err_q        <= 1'b1;
              rdata_q      <= '0;
            end else if (cpu_req_write) begin
              mem_en_q <= 1'b1;
              // Byte writes start with a read of the enclosing halfword.
              rd_en_q  <= (cpu_req_size == 2'b00);
              wr_en_q  <= (cpu_req_size != 2'b00);
              state_q  <= (cpu_req_size == 2'b00) ? RMW_RD : WR0;
            end else begin
              mem_en_q <= 1'b1;
              rd_en_q  <= 1'b1;
              state_q  <= RD0;
            end
          end
        end
        RD0: begin
          if (size_q[1] && !hi_q) begin
            hi_q     <= 1'b1;
            mem_en_q <= 1'b1;
            rd_en_q  <= 1'b1;
            maddr_q  <= maddr_q + ADDR_WIDTH'(1);
          end else begin
            lo_q    <= MEM_MEMCTRL_from_mem_data;
            state_q <= RD1;
          end
        end
        RD1: begin
          rdata_q      <= rd_result(size_q, lane_q, MEM_MEMCTRL_from_mem_data, lo_q);
          resp_valid_q <= 1'b1;
          err_q        <= 1'b0;
          state_q      <= RESP;
        end
        RMW_RD: begin
          mem_en_q <= 1'b1;
          wr_en_q  <= 1'b1;
          state_q  <= RMW_WR;
        end
        RMW_WR: begin
          rdata_q      <= '0;
          resp_valid_q <= 1'b1;
          err_q        <= 1'b0;
          state_q      <= RESP;
        end
        WR0: begin
          if (size_q[1]) begin
            mem_en_q <= 1'b1;
            wr_en_q  <= 1'b1;
            maddr_q  <= maddr_q + ADDR_WIDTH'(1);
            mdata_q  <= wdata_hi_q;
            state_q  <= WR1;
          end else begin
            rdata_q      <= '0;
            resp_valid_q <= 1'b1;
            err_q        <= 1'b0;
            state_q      <= RESP;
          end
        end
        WR1: begin
          rdata_q      <= '0;
          resp_valid_q <= 1'b1;
          err_q        <= 1'b0;
          state_q      <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_req_ready                   = ready_q;
  assign cpu_resp_valid                  = resp_valid_q;
  assign cpu_resp_rdata                  = rdata_q;
  assign cpu_resp_err                    = err_q;
  assign MEMCTRL_MEM_to_mem_read_enable  = rd_en_q;
  assign MEMCTRL_MEM_to_mem_write_enable = wr_en_q;
  assign MEMCTRL_MEM_to_mem_mem_enable   = mem_en_q;
  assign MEMCTRL_MEM_to_mem_address      = maddr_q;
  // The merged halfword depends on read data that only arrives in the write cycle.
  assign MEMCTRL_MEM_to_mem_data = (state_q == RMW_WR) ?
                                   rmw_merge(lane_q, MEM_MEMCTRL_from_mem_data, wbyte_q) :
                                   mdata_q;

endmodule

// File: tb/tb_mem_ctrl16.sv
// Directed bench for mem_ctrl16 with a behavioural 16-bit synchronous memory.
module tb_mem_ctrl16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [12:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [15:0] m_q = '0;
  logic        m_re, m_we, m_en;
  logic [11:0] m_addr;
  logic [15:0] m_wd;
  logic [15:0] mem [0:4095];

  int n_chk = 0;
  int n_fail = 0;

  logic        en_log [0:9];
  logic        rd_log [0:9];
  logic        wr_log [0:9];
  logic [11:0] ad_log [0:9];
  logic [15:0] da_log [0:9];

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t vt [0:23];
  int   nv = 0;

  mem_ctrl16 #(.ADDR_WIDTH(12)) dut (
    .clock                           (clock),
    .reset                           (reset),
    .cpu_req_valid                   (req_valid),
    .cpu_req_ready                   (req_ready),
    .cpu_req_write                   (req_write),
    .cpu_req_size                    (req_size),
    .cpu_req_addr                    (req_addr),
    .cpu_req_wdata                   (req_wdata),
    .cpu_resp_valid                  (resp_valid),
    .cpu_resp_rdata                  (resp_rdata),
    .cpu_resp_err                    (resp_err),
    .MEM_MEMCTRL_from_mem_data       (m_q),
    .MEMCTRL_MEM_to_mem_read_enable  (m_re),
    .MEMCTRL_MEM_to_mem_write_enable (m_we),
    .MEMCTRL_MEM_to_mem_mem_enable   (m_en),
    .MEMCTRL_MEM_to_mem_address      (m_addr),
    .MEMCTRL_MEM_to_mem_data         (m_wd)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (m_en && m_we) mem[m_addr] <= m_wd;
    if (m_en && m_re) m_q <= mem[m_addr];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [1:0] sz, input logic [12:0] a,
                     input logic [31:0] wd, input logic [31:0] erd, input logic ee, input int l);
    vt[nv] = '{w, sz, a, wd, erd, ee, l};
    nv++;
  endtask

  task automatic wait_ready(output int waited);
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    if (!req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
  endtask

  // Issue one request from a negedge and collect the response cycle and data.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic [12:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rdv,
                        output logic er, output int waited);
    logic viol;
    wait_ready(waited);
    req_write = w; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0; req_write = ~w; req_size = ~sz; req_addr = ~a; req_wdata = ~wd;
    lat = 0; rdv = '0; er = 1'b0; viol = 1'b0;
    for (int k = 0; k < 10; k++) begin
      en_log[k] = 1'b0; rd_log[k] = 1'b0; wr_log[k] = 1'b0; ad_log[k] = '0; da_log[k] = '0;
    end
    for (int k = 1; k < 10; k++) begin
      @(negedge clock);
      en_log[k] = m_en; rd_log[k] = m_re; wr_log[k] = m_we; ad_log[k] = m_addr; da_log[k] = m_wd;
      if ((m_re && m_we) || ((m_re || m_we) != m_en)) viol = 1'b1;
      if (resp_valid) begin
        lat = k; rdv = resp_rdata; er = resp_err;
        break;
      end
    end
    chk("strobe_exclusive", 32'(viol), 32'h0);
    if (lat > 0) chk("resp_cycle_no_strobe", 32'(en_log[lat]), 32'h0);
  endtask

  initial begin
    int lat, wt, nresp;
    logic [31:0] rdv;
    logic er;
    logic        r_s [0:9];
    logic        v_s [0:9];
    logic [31:0] d_s [0:9];
    logic        r_e [0:9];
    logic        v_e [0:9];

    // write, size, byte addr, wdata, expected rdata, expected err, response cycle
    add(1, 2'b01, 13'h0002, 32'h00005A5A, 32'h0, 0, 2);
    add(1, 2'b10, 13'h0010, 32'hCAFEBABE, 32'h0, 0, 3);
    add(0, 2'b10, 13'h0010, 32'h0,        32'hCAFEBABE, 0, 4);
    add(0, 2'b01, 13'h0010, 32'h0,        32'h0000BABE, 0, 3);
    add(0, 2'b01, 13'h0012, 32'h0,        32'h0000CAFE, 0, 3);
    add(0, 2'b00, 13'h0011, 32'h0,        32'h000000BA, 0, 3);
    add(0, 2'b00, 13'h0013, 32'h0,        32'h000000CA, 0, 3);
    add(1, 2'b01, 13'h0020, 32'h00001234, 32'h0, 0, 2);
    add(1, 2'b00, 13'h0020, 32'hFFFFFF5A, 32'h0, 0, 3);
    add(0, 2'b01, 13'h0020, 32'h0,        32'h0000125A, 0, 3);
    add(1, 2'b10, 13'h1FFE, 32'h11112222, 32'h0, 0, 3);
    add(0, 2'b10, 13'h1FFE, 32'h0,        32'h11112222, 0, 4);
    add(0, 2'b01, 13'h0000, 32'h0,        32'h00001111, 0, 3);
    add(0, 2'b00, 13'h1FFF, 32'h0,        32'h00000022, 0, 3);
    add(1, 2'b10, 13'h0030, 32'h01020304, 32'h0, 0, 3);
`ifdef MEMCTRL_ALIGN_CHECK_EN
    add(0, 2'b01, 13'h0003, 32'h0,        32'h0, 1, 1);
    add(0, 2'b11, 13'h0010, 32'h0,        32'h0, 1, 1);
    add(1, 2'b10, 13'h0031, 32'hDEADBEEF, 32'h0, 1, 1);
    add(0, 2'b10, 13'h0030, 32'h0,        32'h01020304, 0, 4);
`else
    add(0, 2'b01, 13'h0003, 32'h0,        32'h00005A5A, 0, 3);
    add(0, 2'b11, 13'h0010, 32'h0,        32'hCAFEBABE, 0, 4);
    add(1, 2'b10, 13'h0031, 32'hDEADBEEF, 32'h0, 0, 3);
    add(0, 2'b10, 13'h0030, 32'h0,        32'hDEADBEEF, 0, 4);
`endif

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_strobes", 32'({m_en, m_re, m_we}), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'h0);
    chk("rst_mem_addr_data", {4'h0, m_addr, m_wd}, 32'h0);
    reset = 1'b0;
    chk("rst_ready_after_release", 32'(req_ready), 32'h1);

    for (int i = 0; i < nv; i++) begin
      do_req(vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, lat, rdv, er, wt);
      chk($sformatf("vec%0d_resp_cycle", i), lat, vt[i].exp_lat);
      chk($sformatf("vec%0d_rdata", i), rdv, vt[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
    end

    // Memory image after word writes, including wrap of the last halfword
    chk("mem_h8", 32'(mem[12'h008]), 32'h0000BABE);
    chk("mem_h9", 32'(mem[12'h009]), 32'h0000CAFE);
    chk("mem_hfff", 32'(mem[12'hFFF]), 32'h00002222);
    chk("mem_h000", 32'(mem[12'h000]), 32'h00001111);

    // Byte write read-modify-write strobe sequence
    do_req(1, 2'b01, 13'h0020, 32'h00001234, lat, rdv, er, wt);
    do_req(1, 2'b00, 13'h0021, 32'h000000AB, lat, rdv, er, wt);
    chk("rmw_resp_cycle", lat, 3);
    chk("rmw_c1_read", 32'({en_log[1], rd_log[1], wr_log[1]}), 32'b110);
    chk("rmw_c1_addr", 32'(ad_log[1]), 32'h010);
    chk("rmw_c2_write", 32'({en_log[2], rd_log[2], wr_log[2]}), 32'b101);
    chk("rmw_c2_addr", 32'(ad_log[2]), 32'h010);
    chk("rmw_c2_data", 32'(da_log[2]), 32'h0000AB34);
    chk("rmw_mem", 32'(mem[12'h010]), 32'h0000AB34);

    // Word read issues two back-to-back strobes at h and h+1
    do_req(0, 2'b10, 13'h0010, 32'h0, lat, rdv, er, wt);
    chk("wrd_c1", 32'({en_log[1], rd_log[1], ad_log[1]}), {18'h0, 2'b11, 12'h008});
    chk("wrd_c2", 32'({en_log[2], rd_log[2], ad_log[2]}), {18'h0, 2'b11, 12'h009});
    chk("wrd_c3_idle", 32'(en_log[3]), 32'h0);
    chk("wrd_rdata", rdv, 32'hCAFEBABE);

    // Back-to-back requests with valid held high
    wait_ready(wt);
    r_e = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    v_e = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    req_write = 0; req_size = 2'b01; req_addr = 13'h0020; req_valid = 1'b1;
    r_s[0] = req_ready; v_s[0] = resp_valid; d_s[0] = resp_rdata;
    @(posedge clock);
    #1;
    req_size = 2'b10; req_addr = 13'h0010;
    for (int i = 1; i < 10; i++) begin
      @(negedge clock);
      r_s[i] = req_ready; v_s[i] = resp_valid; d_s[i] = resp_rdata;
      if (i == 4) begin
        @(posedge clock);
        #1;
        req_valid = 1'b0;
      end
    end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("b2b_ready_c%0d", i), 32'(r_s[i]), 32'(r_e[i]));
      chk($sformatf("b2b_valid_c%0d", i), 32'(v_s[i]), 32'(v_e[i]));
    end
    chk("b2b_rdata_first", d_s[3], 32'h0000AB34);
    chk("b2b_rdata_held", d_s[6], 32'h0000AB34);
    chk("b2b_rdata_second", d_s[8], 32'hCAFEBABE);

    // Reset during cycle 1 of a word write: nothing reaches memory
    do_req(1, 2'b01, 13'h0080, 32'h00001111, lat, rdv, er, wt);
    do_req(1, 2'b01, 13'h0082, 32'h00002222, lat, rdv, er, wt);
    wait_ready(wt);
    req_write = 1; req_size = 2'b10; req_addr = 13'h0080; req_wdata = 32'hAAAABBBB; req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    #2;
    chk("abort1_strobe_before", 32'({m_en, m_we}), 32'b11);
    reset = 1'b1;
    #1;
    chk("abort1_strobe_drop", 32'({m_en, m_re, m_we}), 32'h0);
    nresp = 0;
    repeat (2) begin
      @(negedge clock);
      if (resp_valid) nresp++;
    end
    reset = 1'b0;
    chk("abort1_no_resp", nresp, 0);
    chk("abort1_mem_lo", 32'(mem[12'h040]), 32'h00001111);
    chk("abort1_mem_hi", 32'(mem[12'h041]), 32'h00002222);
    chk("abort1_ready", 32'(req_ready), 32'h1);
    do_req(0, 2'b01, 13'h0082, 32'h0, lat, rdv, er, wt);
    chk("post_rst_first_edge", wt, 0);
    chk("post_rst_resp_cycle", lat, 3);
    chk("post_rst_rdata", rdv, 32'h00002222);

    // Reset during cycle 2 of a word write: the low half already landed
    wait_ready(wt);
    req_write = 1; req_size = 2'b10; req_addr = 13'h0080; req_wdata = 32'hCCCCDDDD; req_valid = 1'b1;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("abort2_strobe_drop", 32'({m_en, m_re, m_we}), 32'h0);
    nresp = 0;
    repeat (2) begin
      @(negedge clock);
      if (resp_valid) nresp++;
    end
    reset = 1'b0;
    chk("abort2_no_resp", nresp, 0);
    chk("abort2_mem_lo", 32'(mem[12'h040]), 32'h0000DDDD);
    chk("abort2_mem_hi", 32'(mem[12'h041]), 32'h00002222);
    do_req(0, 2'b10, 13'h0080, 32'h0, lat, rdv, er, wt);
    chk("abort2_readback", rdv, 32'h2222DDDD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
